// File: rtl/game_input_controller_if.sv
// Game-event bus between the input controller (master) and its consumers,
// the audio block and the game core (slave). The game core drives
// game_is_over back to the controller.
interface game_input_controller_if;
  logic jump_pulse;
  logic restart_pulse;
  logic duck_level;
  logic game_is_over;

  modport master (
    output jump_pulse,
    output restart_pulse,
    output duck_level,
    input  game_is_over
  );

  modport slave (
    input  jump_pulse,
    input  restart_pulse,
    input  duck_level,
    output game_is_over
  );
endinterface

// File: rtl/game_input_controller.sv
// Game input controller: synchronises and debounces the jump/duck buttons,
// emits one-cycle jump/restart events and a debounced duck level, and gates
// the events by game phase so a restart needs a holdoff plus a fresh press.
// Optional feature macro: AUTO_REPEAT_EN (auto-repeat jump while held).
module game_input_controller #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16,
  parameter int HOLDOFF_CYCLES  = 5000,
  parameter int REPEAT_CYCLES   = 20000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    btn_jump_raw,
  input  logic                    btn_duck_raw,
  game_input_controller_if.master ev
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

  // Reject configurations the counters cannot represent.
  if (DEBOUNCE_CYCLES < 1 || HOLDOFF_CYCLES < 1 || REPEAT_CYCLES < 1 ||
      DEBOUNCE_CYCLES > (2 ** CNT_W) || HOLDOFF_CYCLES > (2 ** CNT_W) ||
      REPEAT_CYCLES > (2 ** CNT_W)) begin : g_bad_params
    $error("game_input_controller: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_PLAYING      = 2'd0,
    ST_HOLDOFF      = 2'd1,
    ST_WAIT_RELEASE = 2'd2,
    ST_ARMED        = 2'd3
  } state_t;

  // Bit 0 is the jump button, bit 1 the duck button.
  logic [1:0] raw_btn;
  logic [1:0] stable_lvl;

  assign raw_btn = {btn_duck_raw, btn_jump_raw};

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_btn
    logic             sync1_reg;
    logic             sync2_reg;
    logic             stable_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Two-flop synchroniser followed by a consecutive-cycles debouncer.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_reg  <= 1'b0;
        sync2_reg  <= 1'b0;
        stable_reg <= 1'b0;
        cnt_reg    <= '0;
      end else begin
        sync1_reg <= raw_btn[gi];
        sync2_reg <= sync1_reg;
        if (sync2_reg == stable_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == DEB_LAST) begin
          stable_reg <= ~stable_reg;
          cnt_reg    <= '0;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end

    assign stable_lvl[gi] = stable_reg;
  end

  state_t           state_reg;
  logic [CNT_W-1:0] hold_cnt_reg;
  logic             jump_prev_reg;
  logic             jump_pulse_reg;
  logic             restart_pulse_reg;
  logic             duck_level_reg;
  logic             jump_stable;
  logic             jump_rise;

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rep_cnt_reg;
`endif

  assign jump_stable = stable_lvl[0];
  // High for the one cycle in which the debounced jump level has just risen.
  assign jump_rise   = jump_stable & ~jump_prev_reg;

  // Phase FSM with registered event outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= ST_PLAYING;
      hold_cnt_reg      <= '0;
      jump_prev_reg     <= 1'b0;
      jump_pulse_reg    <= 1'b0;
      restart_pulse_reg <= 1'b0;
      duck_level_reg    <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rep_cnt_reg       <= '0;
`endif
    end else begin
      jump_pulse_reg    <= 1'b0;
      restart_pulse_reg <= 1'b0;
      duck_level_reg    <= stable_lvl[1];
      jump_prev_reg     <= jump_stable;
`ifdef AUTO_REPEAT_EN
      // Repeat timing only runs while playing; overridden below in PLAYING.
      if (state_reg != ST_PLAYING) rep_cnt_reg <= '0;
`endif
      case (state_reg)
        ST_PLAYING: begin
          if (ev.game_is_over) begin
            // Game over wins over a same-cycle jump edge.
            state_reg    <= ST_HOLDOFF;
            hold_cnt_reg <= '0;
`ifdef AUTO_REPEAT_EN
            rep_cnt_reg  <= '0;
`endif
          end else if (jump_rise) begin
            jump_pulse_reg <= 1'b1;
`ifdef AUTO_REPEAT_EN
            rep_cnt_reg    <= '0;
`endif
          end
`ifdef AUTO_REPEAT_EN
          else if (!jump_stable) begin
            rep_cnt_reg <= '0;
          end else if (rep_cnt_reg == REP_LAST) begin
            jump_pulse_reg <= 1'b1;
            rep_cnt_reg    <= '0;
          end else begin
            rep_cnt_reg <= rep_cnt_reg + CNT_W'(1);
          end
`endif
        end
        ST_HOLDOFF: begin
          if (!ev.game_is_over) begin
            state_reg <= ST_PLAYING;
          end else if (hold_cnt_reg == HOLD_LAST) begin
            state_reg <= ST_WAIT_RELEASE;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + CNT_W'(1);
          end
        end
        ST_WAIT_RELEASE: begin
          // A button still held from gameplay must be released first.
          if (!ev.game_is_over) begin
            state_reg <= ST_PLAYING;
          end else if (!jump_stable) begin
            state_reg <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (jump_rise) begin
            restart_pulse_reg <= 1'b1;
            state_reg         <= ST_PLAYING;
          end else if (!ev.game_is_over) begin
            state_reg <= ST_PLAYING;
          end
        end
        default: begin
          state_reg <= ST_PLAYING;
        end
      endcase
    end
  end

  assign ev.jump_pulse    = jump_pulse_reg;
  assign ev.restart_pulse = restart_pulse_reg;
  assign ev.duck_level    = duck_level_reg;

endmodule

// File: tb/tb_game_input_controller.sv
// Directed testbench for game_input_controller (DEBOUNCE_CYCLES=4,
// HOLDOFF_CYCLES=8, REPEAT_CYCLES=10). Expectations follow AUTO_REPEAT_EN.
module tb_game_input_controller;
  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int REP  = 10;
  // Raw edge to registered output: 2 sync + DEB debounce + 1 output register.
  localparam int LAT  = 2 + DEB + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_jump_raw = 1'b0;
  logic btn_duck_raw = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int jp_cnt = 0;
  int rp_cnt = 0;
  int overlap = 0;
  int rp_last = -1;
  int jp_q[$];

  game_input_controller_if gif();

  game_input_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(16),
    .HOLDOFF_CYCLES(HOLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_jump_raw(btn_jump_raw),
    .btn_duck_raw(btn_duck_raw),
    .ev(gif)
  );

  always #5 clk = ~clk;

  // Advance one clock, sample 1 time unit after the edge, log events.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (gif.jump_pulse === 1'b1) begin
      jp_cnt++;
      jp_q.push_back(cyc);
    end
    if (gif.restart_pulse === 1'b1) begin
      rp_cnt++;
      rp_last = cyc;
    end
    if (gif.jump_pulse === 1'b1 && gif.restart_pulse === 1'b1) overlap++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    int n0;
    btn_jump_raw = 1'b1;
    btn_duck_raw = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if ({gif.jump_pulse, gif.restart_pulse, gif.duck_level} !== 3'b000) begin
        bad++;
        $display("FAIL reset_outputs cycle=%0d got=%b want=000", cyc,
                 {gif.jump_pulse, gif.restart_pulse, gif.duck_level});
      end
    end
    n0 = jp_cnt;
    rst = 1'b0;
    run(LAT - 1);
    total++;
    if (jp_cnt - n0 !== 0 || gif.duck_level !== 1'b0) begin
      bad++;
      $display("FAIL reset_early jumps=%0d duck=%b want 0/0", jp_cnt - n0, gif.duck_level);
    end
    tick();
    total++;
    if (gif.jump_pulse !== 1'b1) begin
      bad++;
      $display("FAIL reset_jump_latency got=%b want=1 at %0d cycles", gif.jump_pulse, LAT);
    end
    total++;
    if (gif.duck_level !== 1'b1) begin
      bad++;
      $display("FAIL reset_duck_latency got=%b want=1", gif.duck_level);
    end
    tick();
    total++;
    if (gif.jump_pulse !== 1'b0) begin
      bad++;
      $display("FAIL reset_jump_width got=%b want=0", gif.jump_pulse);
    end
    btn_jump_raw = 1'b0;
    btn_duck_raw = 1'b0;
    run(12);
    total++;
    if (jp_cnt - n0 !== 1 || gif.duck_level !== 1'b0 || rp_cnt !== 0) begin
      bad++;
      $display("FAIL reset_settle jumps=%0d duck=%b restarts=%0d want 1/0/0",
               jp_cnt - n0, gif.duck_level, rp_cnt);
    end
    $display("test_reset: done at cycle %0d", cyc);
  endtask

  task automatic test_glitch_and_press();
    int n0;
    int c0;
    n0 = jp_cnt;
    btn_jump_raw = 1'b1;
    run(DEB - 1);
    btn_jump_raw = 1'b0;
    run(15);
    total++;
    if (jp_cnt - n0 !== 0) begin
      bad++;
      $display("FAIL glitch_jump got=%0d pulses want=0", jp_cnt - n0);
    end
    n0 = jp_q.size();
    c0 = cyc;
    btn_jump_raw = 1'b1;
    run(10);
    btn_jump_raw = 1'b0;
    run(20);
    total++;
    if (jp_q.size() - n0 !== 1) begin
      bad++;
      $display("FAIL press_count got=%0d want=1", jp_q.size() - n0);
    end else begin
      total++;
      if (jp_q[n0] !== c0 + LAT) begin
        bad++;
        $display("FAIL press_latency got=%0d want=%0d", jp_q[n0] - c0, LAT);
      end
    end
    $display("test_glitch_and_press: done at cycle %0d", cyc);
  endtask

  task automatic test_duck();
    int j0;
    int r0;
    j0 = jp_cnt;
    r0 = rp_cnt;
    btn_duck_raw = 1'b1;
    run(LAT - 1);
    total++;
    if (gif.duck_level !== 1'b0) begin
      bad++;
      $display("FAIL duck_rise_early got=%b want=0", gif.duck_level);
    end
    tick();
    total++;
    if (gif.duck_level !== 1'b1) begin
      bad++;
      $display("FAIL duck_rise got=%b want=1", gif.duck_level);
    end
    run(20 - LAT);
    btn_duck_raw = 1'b0;
    run(LAT - 1);
    total++;
    if (gif.duck_level !== 1'b1) begin
      bad++;
      $display("FAIL duck_fall_early got=%b want=1", gif.duck_level);
    end
    tick();
    total++;
    if (gif.duck_level !== 1'b0) begin
      bad++;
      $display("FAIL duck_fall got=%b want=0", gif.duck_level);
    end
    run(20 - LAT);
    total++;
    if (jp_cnt - j0 !== 0 || rp_cnt - r0 !== 0) begin
      bad++;
      $display("FAIL duck_no_events jumps=%0d restarts=%0d want 0/0", jp_cnt - j0, rp_cnt - r0);
    end
    $display("test_duck: done at cycle %0d", cyc);
  endtask

  task automatic test_holdoff_restart();
    int j0;
    int r0;
    int c0;
    j0 = jp_cnt;
    btn_jump_raw = 1'b1;
    run(LAT + 1);
    total++;
    if (jp_cnt - j0 !== 1) begin
      bad++;
      $display("FAIL holdoff_prejump got=%0d want=1", jp_cnt - j0);
    end
    j0 = jp_cnt;
    r0 = rp_cnt;
    gif.game_is_over = 1'b1;
    run(HOLD + 12);
    total++;
    if (jp_cnt - j0 !== 0 || rp_cnt - r0 !== 0) begin
      bad++;
      $display("FAIL holdoff_held jumps=%0d restarts=%0d want 0/0", jp_cnt - j0, rp_cnt - r0);
    end
    btn_jump_raw = 1'b0;
    run(10);
    c0 = cyc;
    btn_jump_raw = 1'b1;
    run(LAT + 1);
    total++;
    if (rp_cnt - r0 !== 1 || rp_last !== c0 + LAT) begin
      bad++;
      $display("FAIL restart_pulse count=%0d at=%0d want 1 at %0d", rp_cnt - r0, rp_last - c0, LAT);
    end
    total++;
    if (jp_cnt - j0 !== 0) begin
      bad++;
      $display("FAIL restart_no_jump got=%0d want=0", jp_cnt - j0);
    end
    // Still over and still held: a second restart needs a release first.
    r0 = rp_cnt;
    run(HOLD + 15);
    total++;
    if (rp_cnt - r0 !== 0 || jp_cnt - j0 !== 0) begin
      bad++;
      $display("FAIL restart_rehold restarts=%0d jumps=%0d want 0/0", rp_cnt - r0, jp_cnt - j0);
    end
    gif.game_is_over = 1'b0;
    run(3);
    btn_jump_raw = 1'b0;
    run(12);
    total++;
    if (jp_cnt - j0 !== 0) begin
      bad++;
      $display("FAIL resume_no_jump got=%0d want=0", jp_cnt - j0);
    end
    $display("test_holdoff_restart: done at cycle %0d", cyc);
  endtask

  task automatic test_same_cycle();
    int j0;
    int r0;
    int c0;
    j0 = jp_cnt;
    r0 = rp_cnt;
    btn_jump_raw = 1'b1;
    run(LAT - 1);
    // The debounced edge is now pending; raise game over in the same cycle.
    gif.game_is_over = 1'b1;
    tick();
    total++;
    if (gif.jump_pulse !== 1'b0 || gif.restart_pulse !== 1'b0) begin
      bad++;
      $display("FAIL same_cycle jump=%b restart=%b want 0/0", gif.jump_pulse, gif.restart_pulse);
    end
    run(3);
    gif.game_is_over = 1'b0;
    run(3);
    btn_jump_raw = 1'b0;
    run(10);
    total++;
    if (jp_cnt - j0 !== 0 || rp_cnt - r0 !== 0) begin
      bad++;
      $display("FAIL same_cycle_after jumps=%0d restarts=%0d want 0/0", jp_cnt - j0, rp_cnt - r0);
    end
    c0 = cyc;
    j0 = jp_q.size();
    btn_jump_raw = 1'b1;
    run(LAT + 2);
    total++;
    if (jp_q.size() - j0 !== 1 || jp_q[jp_q.size() - 1] !== c0 + LAT) begin
      bad++;
      $display("FAIL resume_jump count=%0d want=1 at %0d", jp_q.size() - j0, LAT);
    end
    btn_jump_raw = 1'b0;
    run(12);
    $display("test_same_cycle: done at cycle %0d", cyc);
  endtask

  task automatic test_repeat();
    int n0;
    int c0;
    int exp_n;
`ifdef AUTO_REPEAT_EN
    exp_n = 4;
`else
    exp_n = 1;
`endif
    n0 = jp_q.size();
    c0 = cyc;
    btn_jump_raw = 1'b1;
    run(35);
    btn_jump_raw = 1'b0;
    run(20);
    total++;
    if (jp_q.size() - n0 !== exp_n) begin
      bad++;
      $display("FAIL repeat_count got=%0d want=%0d", jp_q.size() - n0, exp_n);
    end else begin
      for (int i = 0; i < exp_n; i++) begin
        total++;
        if (jp_q[n0 + i] !== c0 + LAT + REP * i) begin
          bad++;
          $display("FAIL repeat_pos idx=%0d got=%0d want=%0d", i, jp_q[n0 + i] - c0, LAT + REP * i);
        end
      end
    end
    $display("test_repeat: %0d pulses at cycle %0d", jp_q.size() - n0, cyc);
  endtask

  task automatic test_exclusive();
    total++;
    if (overlap !== 0) begin
      bad++;
      $display("FAIL exclusive got=%0d overlapping cycles want=0", overlap);
    end
    $display("test_exclusive: jumps=%0d restarts=%0d", jp_cnt, rp_cnt);
  endtask

  initial begin
    gif.game_is_over = 1'b0;
    test_reset();
    test_glitch_and_press();
    test_duck();
    test_holdoff_restart();
    test_same_cycle();
    test_repeat();
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
